// File: rtl/div_unit_pkg.sv
`default_nettype none
//============================================================================
// Module      : div_unit_pkg
// Description : Shared definitions for the iterative RV32M divider: op
//               encodings (match funct3[1:0]), FSM state encodings and the
//               fixed results for divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
//============================================================================
package div_unit_pkg;

    // Operation encodings, identical to funct3[1:0] of DIV/DIVU/REM/REMU
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // State encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_CALC = c_ST_CALC,
        ST_FIX  = c_ST_FIX,
        ST_DONE = c_ST_DONE
    } div_state_e;

    // Architecturally defined results for the corner cases
    localparam logic [31:0] c_DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] c_OVF_DVD   = 32'h8000_0000;
    localparam logic [31:0] c_OVF_DVS   = 32'hFFFF_FFFF;
    localparam logic [31:0] c_OVF_QUOT  = 32'h8000_0000;
    localparam logic [31:0] c_OVF_REM   = 32'h0000_0000;

    // DIV and REM are the signed flavours (op[0] == 0)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (op[1] == 1)
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
//============================================================================
// Module      : div_unit_if
// Description : Operand and result handshakes of the divider. The master is
//               the execute stage, the slave is div_unit.
// Revision    : 1.0 - initial release
//============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, dividend, divisor, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, dividend, divisor, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface : div_unit_if
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
//============================================================================
// Module      : div_step
// Description : One restoring-division iteration: shift the next dividend
//               bit into the partial remainder, trial-subtract the divisor
//               and keep the difference when no borrow occurs.
// Revision    : 1.0 - initial release
//============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic             dvd_msb,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_next,
    output logic                  q_bit
);

    // The shifted remainder needs WIDTH+1 bits because a divisor with its
    // MSB set can leave a remainder whose MSB is also set.
    logic [WIDTH:0]   w_partial;
    logic [WIDTH+1:0] w_diff;

    // Trial subtract; the extra top bit is the borrow and doubles as compare
    always_comb begin
        w_partial = {rem, dvd_msb};
        w_diff    = {1'b0, w_partial} - {2'b00, divisor};
        q_bit     = ~w_diff[WIDTH+1];
        rem_next  = q_bit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
//============================================================================
// Module      : div_unit
// Description : Iterative RV32M divider (DIV/DIVU/REM/REMU). Restoring
//               division, one quotient bit per cycle; divide-by-zero and
//               signed overflow are answered in a single cycle.
// Revision    : 1.0 - initial release
//============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_unit_if.slave   bus
);

    localparam int               c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST_IT  = c_CW'(WIDTH - 1);

    div_state_e       r_state;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_divisor;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_result;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_signed;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_fixed;

    // Classify the incoming operation and form operand magnitudes
    always_comb begin
        w_signed = op_is_signed(bus.op);
        w_div0   = (bus.divisor == '0);
        w_ovf    = w_signed
                   && (bus.dividend == WIDTH'(c_OVF_DVD))
                   && (bus.divisor  == WIDTH'(c_OVF_DVS));
        w_abs_a  = (w_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        w_abs_b  = (w_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    end

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem     (r_rem),
        .dvd_msb (r_dvd[WIDTH-1]),
        .divisor (r_divisor),
        .rem_next(w_rem_next),
        .q_bit   (w_q_bit)
    );

    // Pick quotient or remainder and restore the sign for signed ops
    always_comb begin
        if (r_is_rem) begin
            w_fixed = r_neg_r ? -r_rem : r_rem;
        end else begin
            w_fixed = r_neg_q ? -r_dvd : r_dvd;
        end
    end

    // Control FSM with iteration counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_divisor   <= '0;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_is_rem   <= op_is_rem(bus.op);
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_div0) begin
                            r_result    <= op_is_rem(bus.op) ? bus.dividend
                                                             : WIDTH'(c_DIV0_QUOT);
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_ovf) begin
                            r_result    <= op_is_rem(bus.op) ? WIDTH'(c_OVF_REM)
                                                             : WIDTH'(c_OVF_QUOT);
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_rem     <= '0;
                            r_dvd     <= w_abs_a;
                            r_divisor <= w_abs_b;
                            r_neg_q   <= w_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            r_neg_r   <= w_signed & bus.dividend[WIDTH-1];
                            r_state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_rem_next;
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST_IT) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result    <= w_fixed;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.busy      = r_busy;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
//============================================================================
// Module      : tb_div_unit
// Description : Directed, table-driven self-checking bench for div_unit.
// Revision    : 1.0 - initial release
//============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one operation, wait for the result and complete the handshake.
    // Latency counts the accept edge as edge 1.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic busy1);
        int n;
        @(negedge clk);
        dif.op       = op;
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        busy1 = dif.busy;
        n = 1;
        while (!dif.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = n;
        res = dif.result;
        if (dif.out_valid) @(posedge clk);
    endtask

    vec_t        vecs[18];
    logic [31:0] res;
    int          lat;
    logic        b1;

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.op        = 2'b00;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b1;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,        32'd14,       34};
        vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,        32'd2,        34};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 34};
        vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 34};
        vecs[4]  = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{DIV_OP_DIVU, 32'hF000_2323,  32'd0,        32'hFFFF_FFFF, 1};
        vecs[6]  = '{DIV_OP_REMU, 32'h0000_1234,  32'd0,        32'h0000_1234, 1};
        vecs[7]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[8]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[9]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        34};
        vecs[10] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 34};
        vecs[11] = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1,        34};
        vecs[12] = '{DIV_OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 34};
        vecs[13] = '{DIV_OP_DIV,  32'd0,          32'd5,        32'd0,        34};
        vecs[14] = '{DIV_OP_REM,  32'd0,          32'd5,        32'd0,        34};
        vecs[15] = '{DIV_OP_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF, 1};
        vecs[16] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9, 1};
        vecs[17] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready",  {31'd0, dif.in_ready},  32'd1);
        check("reset_busy",      {31'd0, dif.busy},      32'd0);
        check("reset_out_valid", {31'd0, dif.out_valid}, 32'd0);
        check("reset_result",    dif.result,             32'd0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, b1);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), {31'd0, b1}, 32'd1);
        end

        // Backpressure: result and in_ready held while out_ready is low
        @(negedge clk);
        dif.out_ready = 1'b0;
        dif.op        = DIV_OP_DIVU;
        dif.dividend  = 32'h1234_5678;
        dif.divisor   = 32'h10;
        dif.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        lat = 1;
        while (!dif.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd34);
        for (int k = 0; k < 5; k++) begin
            check("bp_result",    dif.result,             32'h0123_4567);
            check("bp_out_valid", {31'd0, dif.out_valid}, 32'd1);
            check("bp_in_ready",  {31'd0, dif.in_ready},  32'd0);
            @(posedge clk);
            #1;
        end
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready",  {31'd0, dif.in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, dif.out_valid}, 32'd0);

        // Reset in the middle of CALC discards the operation
        @(negedge clk);
        dif.op       = DIV_OP_DIVU;
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd3;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_in_ready",  {31'd0, dif.in_ready},  32'd1);
        check("rst_mid_busy",      {31'd0, dif.busy},      32'd0);
        check("rst_mid_out_valid", {31'd0, dif.out_valid}, 32'd0);
        check("rst_mid_result",    dif.result,             32'd0);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (dif.out_valid) lat++;
        end
        check("rst_mid_no_spurious", 32'(lat), 32'd0);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, res, lat, b1);
        check("after_rst_result",  res,      32'd3);
        check("after_rst_latency", 32'(lat), 32'd34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
